// File: rtl/lcd_frame_sched.sv
// -----------------------------------------------------------------------------
// lcd_frame_sched
//
// Frame-synchronous display-register scheduler for an LCD pixel generator.
// Measurement updates are captured in a single-entry shadow buffer through a
// valid/ready handshake. They are committed to the display registers only on a
// frame-start event (the falling edge of lcd_vsync). This keeps the displayed
// value frame-atomic.
//
// After reset the panel is held blank with the backlight off for
// STARTUP_FRAMES frame starts. After that the block runs normally.
//
// Optional feature (macro LCD_OVR_BLINK_EN):
//   defined   - a committed over-range flag blinks disp_ovr. It toggles every
//               BLINK_FRAMES frame starts and begins high at the commit.
//   undefined - disp_ovr holds the committed over-range flag steadily.
//   The port list is the same in both builds.
//
// Ports
//   clk          in   pixel clock; all logic runs on its rising edge
//   rst          in   synchronous active-high reset
//   lcd_vsync    in   vertical sync, active-low pulse
//   lcd_de       in   data enable (observed only; it never gates a commit)
//   upd_valid    in   update offered by the measurement core
//   upd_ready    out  shadow buffer empty, so an update can be accepted
//   upd_mode     in   [1:0]  0=R 1=C 2=L 3=none
//   upd_value    in   [15:0] measurement value
//   upd_ovr      in   over-range flag
//   disp_mode    out  [1:0]  committed mode
//   disp_value   out  [15:0] committed value
//   disp_ovr     out  committed (optionally blinking) over-range flag
//   disp_blank   out  force the pixel output to black
//   lcd_bl_en    out  backlight enable
//   frame_cnt    out  [15:0] frame-start counter (wraps)
//   commit_pulse out  one-cycle strobe, high while new display values appear
// -----------------------------------------------------------------------------
module lcd_frame_sched #(
  parameter int unsigned STARTUP_FRAMES = 4,
  parameter int unsigned BLINK_FRAMES   = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_vsync,
  input  logic        lcd_de,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [1:0]  upd_mode,
  input  logic [15:0] upd_value,
  input  logic        upd_ovr,
  output logic [1:0]  disp_mode,
  output logic [15:0] disp_value,
  output logic        disp_ovr,
  output logic        disp_blank,
  output logic        lcd_bl_en,
  output logic [15:0] frame_cnt,
  output logic        commit_pulse
);

  localparam logic [7:0] STARTUP_LIM = 8'(STARTUP_FRAMES);

  typedef enum logic {ST_STARTUP = 1'b0, ST_RUN = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [7:0]  startup_cnt_q, startup_cnt_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        pend_q, pend_d;
  logic [1:0]  sh_mode_q, sh_mode_d;
  logic [15:0] sh_value_q, sh_value_d;
  logic        sh_ovr_q, sh_ovr_d;
  logic [1:0]  disp_mode_q, disp_mode_d;
  logic [15:0] disp_value_q, disp_value_d;
  logic        disp_ovr_q, disp_ovr_d;
  logic        blank_q, blank_d;
  logic        bl_en_q, bl_en_d;
  logic        commit_q, commit_d;
`ifdef LCD_OVR_BLINK_EN
  localparam logic [7:0] BLINK_LIM = 8'(BLINK_FRAMES);
  logic        ovr_cmt_q, ovr_cmt_d;
  logic [7:0]  blink_cnt_q, blink_cnt_d;
`endif

  logic fs, accept, commit;

  // DE is observed only. Malformed timing (a frame start during DE) still
  // commits, so DE takes part in no decision.
  logic unused_de;
  assign unused_de = lcd_de;

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through this block
    // leaves a signal unassigned and no latch is inferred.
    state_d       = state_q;
    startup_cnt_d = startup_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    pend_d        = pend_q;
    sh_mode_d     = sh_mode_q;
    sh_value_d    = sh_value_q;
    sh_ovr_d      = sh_ovr_q;
    disp_mode_d   = disp_mode_q;
    disp_value_d  = disp_value_q;
    disp_ovr_d    = disp_ovr_q;
`ifdef LCD_OVR_BLINK_EN
    ovr_cmt_d     = ovr_cmt_q;
    blink_cnt_d   = blink_cnt_q;
`endif

    // A frame start is a registered-1 followed by a live-0 on vsync.
    vsync_prev_d = lcd_vsync;
    fs           = vsync_prev_q & ~lcd_vsync;
    // Accept and commit are mutually exclusive because of pend_q.
    accept       = upd_valid & ~pend_q;
    commit       = fs & pend_q;

    if (fs) frame_cnt_d = frame_cnt_q + 16'd1;

    unique case (state_q)
      ST_STARTUP: begin
        if (fs) begin
          startup_cnt_d = startup_cnt_q + 8'd1;
          if (startup_cnt_q + 8'd1 == STARTUP_LIM) state_d = ST_RUN;
        end
      end
      ST_RUN: ;
      default: state_d = ST_STARTUP;
    endcase

    // Blanking and backlight follow the state one cycle late.
    blank_d = (state_q == ST_STARTUP);
    bl_en_d = (state_q == ST_RUN);

    if (accept) begin
      sh_mode_d  = upd_mode;
      sh_value_d = upd_value;
      sh_ovr_d   = upd_ovr;
      pend_d     = 1'b1;
    end

    commit_d = commit;
    if (commit) begin
      disp_mode_d  = sh_mode_q;
      disp_value_d = sh_value_q;
      pend_d       = 1'b0;
    end

`ifdef LCD_OVR_BLINK_EN
    if (commit) begin
      ovr_cmt_d   = sh_ovr_q;
      disp_ovr_d  = sh_ovr_q;
      blink_cnt_d = 8'd0;
    end else if (fs && ovr_cmt_q) begin
      if (blink_cnt_q + 8'd1 == BLINK_LIM) begin
        disp_ovr_d  = ~disp_ovr_q;
        blink_cnt_d = 8'd0;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
`else
    if (commit) disp_ovr_d = sh_ovr_q;
`endif
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // whatever the statement order is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_STARTUP;
      startup_cnt_q <= 8'd0;
      vsync_prev_q  <= 1'b1;
      frame_cnt_q   <= 16'd0;
      pend_q        <= 1'b0;
      // NOTE: pend_q alone guards the shadow data. It is reset anyway so that
      // a freshly reset part shows known values everywhere.
      sh_mode_q     <= 2'd3;
      sh_value_q    <= 16'd0;
      sh_ovr_q      <= 1'b0;
      disp_mode_q   <= 2'd3;
      disp_value_q  <= 16'd0;
      disp_ovr_q    <= 1'b0;
      blank_q       <= 1'b1;
      bl_en_q       <= 1'b0;
      commit_q      <= 1'b0;
`ifdef LCD_OVR_BLINK_EN
      ovr_cmt_q     <= 1'b0;
      blink_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q       <= state_d;
      startup_cnt_q <= startup_cnt_d;
      vsync_prev_q  <= vsync_prev_d;
      frame_cnt_q   <= frame_cnt_d;
      pend_q        <= pend_d;
      sh_mode_q     <= sh_mode_d;
      sh_value_q    <= sh_value_d;
      sh_ovr_q      <= sh_ovr_d;
      disp_mode_q   <= disp_mode_d;
      disp_value_q  <= disp_value_d;
      disp_ovr_q    <= disp_ovr_d;
      blank_q       <= blank_d;
      bl_en_q       <= bl_en_d;
      commit_q      <= commit_d;
`ifdef LCD_OVR_BLINK_EN
      ovr_cmt_q     <= ovr_cmt_d;
      blink_cnt_q   <= blink_cnt_d;
`endif
    end
  end

  assign upd_ready    = ~pend_q;
  assign disp_mode    = disp_mode_q;
  assign disp_value   = disp_value_q;
  assign disp_ovr     = disp_ovr_q;
  assign disp_blank   = blank_q;
  assign lcd_bl_en    = bl_en_q;
  assign frame_cnt    = frame_cnt_q;
  assign commit_pulse = commit_q;

endmodule

// File: tb/tb_lcd_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_lcd_frame_sched
//
// Directed testbench for lcd_frame_sched (STARTUP_FRAMES=4, BLINK_FRAMES=2).
// Inputs change 1 ns after a rising edge. Outputs are checked 1 ns after an
// edge, once the registers have settled.
// -----------------------------------------------------------------------------
module tb_lcd_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lcd_vsync = 1'b1;
  logic        lcd_de = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [1:0]  upd_mode = 2'd0;
  logic [15:0] upd_value = 16'd0;
  logic        upd_ovr = 1'b0;
  logic [1:0]  disp_mode;
  logic [15:0] disp_value;
  logic        disp_ovr;
  logic        disp_blank;
  logic        lcd_bl_en;
  logic [15:0] frame_cnt;
  logic        commit_pulse;

  int checks = 0;
  int errors = 0;

  lcd_frame_sched #(.STARTUP_FRAMES(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_mode(upd_mode),
    .upd_value(upd_value), .upd_ovr(upd_ovr), .disp_mode(disp_mode),
    .disp_value(disp_value), .disp_ovr(disp_ovr), .disp_blank(disp_blank),
    .lcd_bl_en(lcd_bl_en), .frame_cnt(frame_cnt), .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full vsync pulse: low for a cycle (frame start on that edge), then high.
  task automatic vsync_pulse();
    lcd_vsync = 1'b0;
    tick();
    lcd_vsync = 1'b1;
    tick();
  endtask

  task automatic offer(input logic [1:0] m, input logic [15:0] v, input logic o);
    upd_valid = 1'b1;
    upd_mode  = m;
    upd_value = v;
    upd_ovr   = o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (disp_blank !== 1'b1) begin errors++; $display("FAIL reset_blank: got %b want 1", disp_blank); end
    checks++; if (lcd_bl_en !== 1'b0) begin errors++; $display("FAIL reset_bl_en: got %b want 0", lcd_bl_en); end
    checks++; if (disp_mode !== 2'd3) begin errors++; $display("FAIL reset_mode: got %0d want 3", disp_mode); end
    checks++; if (disp_value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h want 0000", disp_value); end
    checks++; if (disp_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", disp_ovr); end
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL reset_frame_cnt: got %h want 0000", frame_cnt); end
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b want 0", commit_pulse); end
    rst = 1'b0;
    #1;
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", upd_ready); end
  endtask

  task automatic test_startup();
    for (int i = 0; i < 3; i++) vsync_pulse();
    checks++; if (disp_blank !== 1'b1) begin errors++; $display("FAIL startup_3_blank: got %b want 1", disp_blank); end
    checks++; if (lcd_bl_en !== 1'b0) begin errors++; $display("FAIL startup_3_bl_en: got %b want 0", lcd_bl_en); end
    lcd_vsync = 1'b0;
    tick();  // 4th frame start: the state moves to RUN on this edge
    checks++; if (disp_blank !== 1'b1) begin errors++; $display("FAIL startup_4_blank_early: got %b want 1", disp_blank); end
    lcd_vsync = 1'b1;
    tick();
    checks++; if (disp_blank !== 1'b0) begin errors++; $display("FAIL startup_4_blank: got %b want 0", disp_blank); end
    checks++; if (lcd_bl_en !== 1'b1) begin errors++; $display("FAIL startup_4_bl_en: got %b want 1", lcd_bl_en); end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL startup_frame_cnt: got %h want 0004", frame_cnt); end
  endtask

  task automatic test_commit();
    offer(2'd1, 16'h1234, 1'b0);
    tick();
    upd_valid = 1'b0;
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL commit_ready_low: got %b want 0", upd_ready); end
    tick();
    checks++; if (disp_value !== 16'h0000) begin errors++; $display("FAIL commit_early_value: got %h want 0000", disp_value); end
    lcd_vsync = 1'b0;
    tick();
    checks++; if (disp_value !== 16'h1234) begin errors++; $display("FAIL commit_value: got %h want 1234", disp_value); end
    checks++; if (disp_mode !== 2'd1) begin errors++; $display("FAIL commit_mode: got %0d want 1", disp_mode); end
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL commit_pulse_hi: got %b want 1", commit_pulse); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL commit_ready_back: got %b want 1", upd_ready); end
    lcd_vsync = 1'b1;
    tick();
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL commit_pulse_lo: got %b want 0", commit_pulse); end
  endtask

  task automatic test_back_to_back();
    offer(2'd2, 16'hAAAA, 1'b0);
    tick();  // 0xAAAA accepted
    upd_value = 16'h5555;
    tick();
    tick();
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b want 0", upd_ready); end
    lcd_vsync = 1'b0;
    tick();  // fs1
    checks++; if (disp_value !== 16'hAAAA) begin errors++; $display("FAIL b2b_fs1_value: got %h want aaaa", disp_value); end
    lcd_vsync = 1'b1;
    tick();  // 0x5555 accepted here
    upd_valid = 1'b0;
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got %b want 0", upd_ready); end
    checks++; if (disp_value !== 16'hAAAA) begin errors++; $display("FAIL b2b_hold_value: got %h want aaaa", disp_value); end
    lcd_vsync = 1'b0;
    tick();  // fs2
    checks++; if (disp_value !== 16'h5555) begin errors++; $display("FAIL b2b_fs2_value: got %h want 5555", disp_value); end
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL b2b_fs2_pulse: got %b want 1", commit_pulse); end
    lcd_vsync = 1'b1;
    tick();
  endtask

  task automatic test_same_cycle();
    offer(2'd0, 16'hBEEF, 1'b0);
    lcd_vsync = 1'b0;
    tick();  // accept and fs on the same edge
    upd_valid = 1'b0;
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL same_no_commit: got %b want 0", commit_pulse); end
    checks++; if (disp_value !== 16'h5555) begin errors++; $display("FAIL same_value_held: got %h want 5555", disp_value); end
    lcd_vsync = 1'b1;
    tick();
    lcd_vsync = 1'b0;
    tick();
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL same_next_commit: got %b want 1", commit_pulse); end
    checks++; if (disp_value !== 16'hBEEF) begin errors++; $display("FAIL same_next_value: got %h want beef", disp_value); end
    lcd_vsync = 1'b1;
    tick();
  endtask

  task automatic test_de_malformed();
    offer(2'd2, 16'h0042, 1'b0);
    tick();
    upd_valid = 1'b0;
    lcd_de    = 1'b1;
    lcd_vsync = 1'b0;
    tick();
    checks++; if (disp_value !== 16'h0042) begin errors++; $display("FAIL de_commit_value: got %h want 0042", disp_value); end
    checks++; if (disp_mode !== 2'd2) begin errors++; $display("FAIL de_commit_mode: got %0d want 2", disp_mode); end
    lcd_de    = 1'b0;
    lcd_vsync = 1'b1;
    tick();
  endtask

  task automatic test_ovr();
    logic [3:0] exp_pat;
`ifdef LCD_OVR_BLINK_EN
    exp_pat = 4'b1001;  // frames after the commit: 1,0,0,1 (read MSB first)
`else
    exp_pat = 4'b1111;
`endif
    offer(2'd0, 16'h0009, 1'b1);
    tick();
    upd_valid = 1'b0;
    lcd_vsync = 1'b0;
    tick();
    checks++; if (disp_ovr !== 1'b1) begin errors++; $display("FAIL ovr_commit: got %b want 1", disp_ovr); end
    lcd_vsync = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      lcd_vsync = 1'b0;
      tick();
      checks++;
      if (disp_ovr !== exp_pat[3-i]) begin
        errors++;
        $display("FAIL ovr_frame%0d: got %b want %b", i + 1, disp_ovr, exp_pat[3-i]);
      end
      lcd_vsync = 1'b1;
      tick();
    end
    offer(2'd0, 16'h0009, 1'b0);
    tick();
    upd_valid = 1'b0;
    vsync_pulse();
    vsync_pulse();
    checks++; if (disp_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", disp_ovr); end
  endtask

  task automatic test_wrap_and_reset();
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    checks++; if (frame_cnt !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload: got %h want fffe", frame_cnt); end
    vsync_pulse();
    checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h want ffff", frame_cnt); end
    vsync_pulse();
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", frame_cnt); end
    offer(2'd1, 16'h7777, 1'b0);
    tick();
    upd_valid = 1'b0;
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL rst_pend_set: got %b want 0", upd_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_pend_clear: got %b want 1", upd_ready); end
    checks++; if (disp_mode !== 2'd3) begin errors++; $display("FAIL rst_mode: got %0d want 3", disp_mode); end
    checks++; if (disp_value !== 16'h0000) begin errors++; $display("FAIL rst_value: got %h want 0000", disp_value); end
    checks++; if (disp_blank !== 1'b1) begin errors++; $display("FAIL rst_blank: got %b want 1", disp_blank); end
    lcd_vsync = 1'b0;
    tick();
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL rst_dropped_commit: got %b want 0", commit_pulse); end
    checks++; if (disp_value !== 16'h0000) begin errors++; $display("FAIL rst_dropped_value: got %h want 0000", disp_value); end
    lcd_vsync = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_commit();
    test_back_to_back();
    test_same_cycle();
    test_de_malformed();
    test_ovr();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
